load_whb_unit: RTL and testbench

- Load-side counterpart of the store data formatter.
- Accepts one load request from the MEM stage and issues a word-aligned read to data memory over a req/gnt/rvalid handshake.
- Extracts the byte, half-word or word from the returned data, then sign- or zero-extends it.
- Holds the result for writeback under a valid/ready handshake; one load outstanding at a time.

---
 rtl/load_whb_unit_if.sv | 36 +++
 rtl/load_whb_unit.sv | 132 +++++++++++++
 tb/tb_load_whb_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_whb_unit_if.sv
// rtl/load_whb_unit_if.sv - load request, data-memory read and writeback signal bundle for load_whb_unit
interface load_whb_unit_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [1:0]  ld_whb;
    logic        ld_unsigned;
    logic [4:0]  ld_rd;

    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;
    logic        wb_misalign;

    modport master (
        input  ld_valid, ld_addr, ld_whb, ld_unsigned, ld_rd,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, wb_ready,
        output ld_ready, dmem_req, dmem_addr,
        output wb_valid, wb_data, wb_rd, wb_err, wb_misalign
    );

    modport slave (
        output ld_valid, ld_addr, ld_whb, ld_unsigned, ld_rd,
        output dmem_gnt, dmem_rvalid, dmem_rdata, wb_ready,
        input  ld_ready, dmem_req, dmem_addr,
        input  wb_valid, wb_data, wb_rd, wb_err, wb_misalign
    );
endinterface

// File: rtl/load_whb_unit.sv
// rtl/load_whb_unit.sv - single-outstanding load unit: aligned dmem read, byte/half/word extract, sign/zero extend
// Optional macro MISALIGN_TRAP_EN: trap misaligned half/word loads instead of issuing them.
module load_whb_unit #(
    parameter int         TIMEOUT_W = 8,
    parameter logic [1:0] BYTE_ENC  = 2'b00,
    parameter logic [1:0] HALF_ENC  = 2'b01,
    parameter logic [1:0] WORD_ENC  = 2'b10
) (
    input  logic            clk,
    input  logic            rst_n,
    load_whb_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_off;
    logic [1:0]           r_whb;
    logic                 r_unsigned;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [31:0]          r_dmem_addr;
    logic [31:0]          r_wb_data;
    logic [4:0]           r_wb_rd;
    logic                 r_wb_err;

    logic                 w_illegal;
    logic                 w_misalign;
    logic                 w_timeout;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_fmt;

    assign w_illegal = (bus.ld_whb != BYTE_ENC) && (bus.ld_whb != HALF_ENC) && (bus.ld_whb != WORD_ENC);

`ifdef MISALIGN_TRAP_EN
    logic r_wb_mis;
    assign w_misalign = ((bus.ld_whb == HALF_ENC) && bus.ld_addr[0]) ||
                        ((bus.ld_whb == WORD_ENC) && (bus.ld_addr[1:0] != 2'b00));
    assign bus.wb_misalign = r_wb_mis;
`else
    assign w_misalign      = 1'b0;
    assign bus.wb_misalign = 1'b0;
`endif

    // Timeout on the WAIT cycle whose increment lands on all-ones.
    assign w_timeout = (r_cnt + TIMEOUT_W'(1)) == {TIMEOUT_W{1'b1}};

    always_comb begin
        w_byte = 8'(bus.dmem_rdata >> {r_off, 3'b000});
        w_half = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        if (r_whb == BYTE_ENC)
            w_fmt = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        else if (r_whb == HALF_ENC)
            w_fmt = {{16{~r_unsigned & w_half[15]}}, w_half};
        else
            w_fmt = bus.dmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.ld_valid) w_next = (w_illegal || w_misalign) ? S_RESP : S_REQ;
            S_REQ:  if (bus.dmem_gnt) w_next = S_WAIT;
            S_WAIT: if (bus.dmem_rvalid || w_timeout) w_next = S_RESP;
            S_RESP: if (bus.wb_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ld_ready = (r_state == S_IDLE);
        bus.dmem_req = (r_state == S_REQ);
        bus.wb_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_off       <= 2'b00;
            r_whb       <= 2'b00;
            r_unsigned  <= 1'b0;
            r_cnt       <= '0;
            r_dmem_addr <= 32'h0;
            r_wb_data   <= 32'h0;
            r_wb_rd     <= 5'h0;
            r_wb_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_wb_mis    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.ld_valid) begin
                    r_off       <= bus.ld_addr[1:0];
                    r_whb       <= bus.ld_whb;
                    r_unsigned  <= bus.ld_unsigned;
                    r_wb_rd     <= bus.ld_rd;
                    r_dmem_addr <= {bus.ld_addr[31:2], 2'b00};
                    if (w_illegal || w_misalign) begin
                        r_wb_data <= 32'h0;
                        r_wb_err  <= 1'b1;
                    end
`ifdef MISALIGN_TRAP_EN
                    r_wb_mis <= w_misalign;
`endif
                end
                S_REQ: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + TIMEOUT_W'(1);
                    if (bus.dmem_rvalid) begin
                        r_wb_data <= w_fmt;
                        r_wb_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_wb_data <= 32'h0;
                        r_wb_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dmem_addr = r_dmem_addr;
    assign bus.wb_data   = r_wb_data;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_err    = r_wb_err;
endmodule

// File: tb/tb_load_whb_unit.sv
// tb/tb_load_whb_unit.sv - self-checking bench for load_whb_unit with directed and random loads
module tb_load_whb_unit;
    localparam int TW       = 3;
    localparam int WAIT_MAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    load_whb_unit_if bus ();

    load_whb_unit #(.TIMEOUT_W(TW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_fmt(input logic [31:0] rdata, input int off,
                                              input logic [1:0] whb, input bit uns);
        longint v;
        if (whb == 2'b00) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (whb == 2'b01) begin
            v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = rdata;
        end
        return 32'(v);
    endfunction

    function automatic bit model_mis(input int off, input logic [1:0] whb);
`ifdef MISALIGN_TRAP_EN
        return (whb == 2'b01 && (off % 2) != 0) || (whb == 2'b10 && off != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_resp(input string ph, input logic [31:0] d, input logic [4:0] rd,
                              input bit err, input bit mis);
        chk({ph, "_wb_valid"}, bus.wb_valid, 1);
        chk({ph, "_wb_data"},  bus.wb_data, d);
        chk({ph, "_wb_rd"},    bus.wb_rd, rd);
        chk({ph, "_wb_err"},   bus.wb_err, err);
        chk({ph, "_wb_mis"},   bus.wb_misalign, mis);
        chk({ph, "_no_req"},   bus.dmem_req, 0);
        chk({ph, "_ld_ready"}, bus.ld_ready, 0);
    endtask

    // gdly: cycles of gnt low in REQ; rdly: idle WAIT cycles before rvalid (>= WAIT_MAX times out);
    // wdly: cycles of wb_ready low in RESP
    task automatic run_load(input logic [31:0] addr, input logic [1:0] whb, input bit uns,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input int gdly, input int rdly, input int wdly);
        int          off;
        bit          mis, bad, tmo;
        logic [31:0] exp_d;
        int          nwait;
        off   = int'(addr[1:0]);
        mis   = model_mis(off, whb);
        bad   = (whb == 2'b11) || mis;
        tmo   = !bad && (rdly >= WAIT_MAX);
        exp_d = (bad || tmo) ? 32'h0 : model_fmt(rdata, off, whb, uns);

        bus.dmem_rvalid = 1'b1;
        bus.dmem_gnt    = 1'b1;
        tick();
        bus.dmem_rvalid = 1'b0;
        bus.dmem_gnt    = 1'b0;
        chk("idle_stray_wb_valid", bus.wb_valid, 0);
        chk("idle_ld_ready", bus.ld_ready, 1);

        bus.ld_valid    = 1'b1;
        bus.ld_addr     = addr;
        bus.ld_whb      = whb;
        bus.ld_unsigned = uns;
        bus.ld_rd       = rd;
        tick();
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = $urandom;
        bus.ld_whb      = 2'($urandom);
        bus.ld_unsigned = 1'($urandom);
        bus.ld_rd       = 5'($urandom);

        if (!bad) begin
            for (int i = 0; i < gdly; i++) begin
                chk("req_hold", bus.dmem_req, 1);
                chk("addr_hold", bus.dmem_addr, {addr[31:2], 2'b00});
                chk("busy_ld_ready", bus.ld_ready, 0);
                tick();
            end
            chk("req", bus.dmem_req, 1);
            chk("dmem_addr", bus.dmem_addr, {addr[31:2], 2'b00});
            bus.dmem_gnt = 1'b1;
            tick();
            bus.dmem_gnt = 1'b0;
            nwait = tmo ? WAIT_MAX : rdly;
            for (int i = 0; i < nwait; i++) begin
                chk("wait_req_drop", bus.dmem_req, 0);
                chk("wait_wb_valid", bus.wb_valid, 0);
                tick();
            end
            if (!tmo) begin
                chk("wait_wb_valid", bus.wb_valid, 0);
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = rdata;
                tick();
                bus.dmem_rvalid = 1'b0;
                bus.dmem_rdata  = $urandom;
            end
        end

        for (int i = 0; i < wdly; i++) begin
            check_resp("resp_hold", exp_d, rd, bad || tmo, mis);
            bus.dmem_rvalid = (i == 0) ? 1'b1 : 1'($urandom);
            bus.dmem_gnt    = 1'($urandom);
            bus.dmem_rdata  = $urandom;
            tick();
            bus.dmem_rvalid = 1'b0;
            bus.dmem_gnt    = 1'b0;
        end
        check_resp("resp", exp_d, rd, bad || tmo, mis);

        bus.wb_ready    = 1'b1;
        bus.ld_valid    = 1'b1;
        bus.ld_whb      = 2'b00;
        tick();
        bus.wb_ready    = 1'b0;
        bus.ld_valid    = 1'b0;
        chk("post_wb_valid", bus.wb_valid, 0);
        chk("post_ld_ready", bus.ld_ready, 1);
        chk("post_no_accept", bus.dmem_req, 0);
    endtask

    task automatic check_reset_outputs(input string ph);
        chk({ph, "_ld_ready"},  bus.ld_ready, 1);
        chk({ph, "_dmem_req"},  bus.dmem_req, 0);
        chk({ph, "_dmem_addr"}, bus.dmem_addr, 0);
        chk({ph, "_wb_valid"},  bus.wb_valid, 0);
        chk({ph, "_wb_data"},   bus.wb_data, 0);
        chk({ph, "_wb_rd"},     bus.wb_rd, 0);
        chk({ph, "_wb_err"},    bus.wb_err, 0);
        chk({ph, "_wb_mis"},    bus.wb_misalign, 0);
    endtask

    initial begin
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = 32'h0;
        bus.ld_whb      = 2'b00;
        bus.ld_unsigned = 1'b0;
        bus.ld_rd       = 5'h0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;
        bus.wb_ready    = 1'b0;
        rst_n           = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_load(32'h0000_1003, 2'b00, 1'b0, 5'd3,  32'h80FF_1234, 0, 0, 0);
        run_load(32'h0000_2002, 2'b01, 1'b1, 5'd7,  32'h9ABC_0000, 0, 0, 1);
        run_load(32'h0000_2002, 2'b01, 1'b0, 5'd8,  32'h9ABC_0000, 0, 0, 1);
        run_load(32'h0000_4001, 2'b00, 1'b1, 5'd9,  32'h1234_F600, 3, 1, 4);
        run_load(32'h0000_5000, 2'b10, 1'b0, 5'd10, 32'hCAFE_BABE, 0, WAIT_MAX, 2);
        run_load(32'h0000_5004, 2'b10, 1'b0, 5'd11, 32'h1357_9BDF, 1, WAIT_MAX - 1, 1);
        run_load(32'h0000_6000, 2'b11, 1'b0, 5'd12, 32'hFFFF_FFFF, 0, 0, 2);
        run_load(32'h0000_3002, 2'b10, 1'b0, 5'd13, 32'hDEAD_BEEF, 0, 0, 1);
        run_load(32'h0000_3001, 2'b01, 1'b0, 5'd14, 32'h8001_8002, 0, 0, 0);

        // Reset while WAIT, then a stale rvalid must not produce a result
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_7008;
        bus.ld_whb   = 2'b10;
        bus.ld_rd    = 5'd21;
        tick();
        bus.ld_valid = 1'b0;
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        rst_n           = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_AAAA;
        tick();
        bus.dmem_rvalid = 1'b0;
        chk("stale_rvalid_wb_valid", bus.wb_valid, 0);
        chk("stale_rvalid_ld_ready", bus.ld_ready, 1);
        tick();
        chk("stale_rvalid_wb_valid2", bus.wb_valid, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] whb;
            whb = 2'($urandom_range(0, 3));
            run_load($urandom, whb, 1'($urandom), 5'($urandom), $urandom,
                     $urandom_range(0, 3), $urandom_range(0, WAIT_MAX + 1), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
